uart_rx_core: RTL and testbench
===============================

UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_BITS, default 8, sets data bits per frame (legal 5..8).
REQ-002 Parameter OVERSAMPLE, default 16, sets sample_tick pulses per bit period (even, 8..16).
REQ-003 Parameter PARITY_EN, default 0: 1 = one parity bit after data, 0 = none.
REQ-004 Parameter PARITY_ODD, default 0: 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 enable_rx  input  1  receiver enable; low aborts any frame in progress.
REQ-008 sample_tick  input  1  one-clk pulse at OVERSAMPLE x baud, from the baud selector block.
REQ-009 rx_serial  input  1  asynchronous serial line, idle high.
REQ-010 rd_ack  input  1  one-clk pulse; consumer has taken rx_data.
REQ-011 rx_data  output  DATA_BITS  last received byte, LSB = first data bit received.
REQ-012 rx_valid  output  1  rx_data holds an unread byte.
REQ-013 frame_err  output  1  held byte had stop bit sampled 0.
REQ-014 parity_err  output  1  held byte failed the parity check.
REQ-015 overrun_err  output  1  sticky; a byte was overwritten while unread.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 rx_serial shall pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-018 The FSM states shall be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. The tick counter shall advance only on sample_tick.
REQ-019 IDLE: on a sample_tick with rxs=0, go to START and clear the tick counter.
REQ-020 START: on the tick where the counter reaches OVERSAMPLE/2-1, rxs=0 goes to DATA with the counter cleared. rxs=1 is a false start and returns to IDLE with no output change.
REQ-021 DATA: on each tick where the counter reaches OVERSAMPLE-1, shift rxs in LSB-first and clear the counter. After DATA_BITS samples, go to PARITY if PARITY_EN=1, else go to STOP.
REQ-022 PARITY: sample at counter OVERSAMPLE-1. The error flag is the XOR of the data bits and the parity bit, inverted when PARITY_ODD=1; a nonzero flag flags a parity error. Then go to STOP.
REQ-023 STOP: sample at counter OVERSAMPLE-1, then commit the frame.
  - Stop sample 1: go to IDLE.
  - Stop sample 0: go to WAIT_HIGH.
REQ-024 WAIT_HIGH: stay until rxs=1, then go to IDLE.
REQ-025 Commit: on the clk after the stop sample, load rx_data, frame_err and parity_err together and set rx_valid=1. A byte with errors is still committed.
REQ-026 rx_valid shall clear on the clk after rd_ack. rd_ack while rx_valid=0 has no effect.
REQ-027 Commit while rx_valid=1 with no rd_ack in the same cycle: overwrite rx_data and the error flags and set overrun_err.
REQ-028 Commit and rd_ack in the same cycle: load the new byte, keep rx_valid=1, leave overrun_err unchanged.
REQ-029 overrun_err shall clear only on rd_ack with no commit in the same cycle, or on reset.
REQ-030 enable_rx=0: the next clk forces IDLE and clears the counter and shift register. rx_data, rx_valid and the error flags are kept. No start is detected while enable_rx=0.
REQ-031 sample_tick absent: the FSM holds state indefinitely; there is no timeout.

Reset
REQ-032 With rst=0 at a posedge, the next state shall be:
  - state IDLE; counter and shift register 0;
  - rx_data, rx_valid, frame_err, parity_err, overrun_err and busy all 0;
  - both synchronizer flops 1.
REQ-033 Reset mid-frame shall discard the frame and produce no commit. Reset has priority over all other inputs.

Verification
REQ-034 8N1, OVERSAMPLE=16, sample_tick every clk, frame 0xA5 -> rx_data=0xA5, rx_valid=1 about 160 clks after the start edge, all error flags 0, busy low after the stop bit.
REQ-035 Low glitch of 4 ticks on rx_serial -> START aborts at tick 8, rx_valid stays 0, FSM in IDLE.
REQ-036 Frame 0x3C with stop bit 0 -> rx_data=0x3C, frame_err=1. FSM holds in WAIT_HIGH until the line returns high, then the next frame 0x11 is received correctly.
REQ-037 Two frames 0x01 then 0x02 with no rd_ack -> rx_data=0x02, overrun_err=1. rd_ack then gives rx_valid=0 and overrun_err=0.
REQ-038 PARITY_EN=1, even parity, 0x07 with parity bit 0 -> parity_err=1. The same byte with parity bit 1 -> parity_err=0.
REQ-039 enable_rx dropped after data bit 3, then raised and frame 0x5A sent -> no commit from the aborted frame, rx_data=0x5A. rst pulsed mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver with a 2-flop line synchronizer,
// optional parity, and a one-entry holding register with frame/parity/overrun flags.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_rx,
    input  logic                 sample_tick,
    input  logic                 rx_serial,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = 3;
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 par_flag_q, par_flag_d;
    logic                 stop_bit_q, stop_bit_d;
    logic                 commit_q, commit_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 rxs;

    assign rxs = sync2_q;

    // State register and all flops; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            par_flag_q   <= 1'b0;
            stop_bit_q   <= 1'b1;
            commit_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            par_flag_q   <= par_flag_d;
            stop_bit_q   <= stop_bit_d;
            commit_q     <= commit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    // Next state: frame sequencing, tick counting and bit capture.
    always_comb begin
        sync1_d    = rx_serial;
        sync2_d    = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_flag_d = par_flag_q;
        stop_bit_d = stop_bit_q;
        commit_d   = 1'b0;
        if (!enable_rx) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            par_flag_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sample_tick && !rxs) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (sample_tick) begin
                        if (cnt_q == HALF_M1) begin
                            cnt_d     = '0;
                            bit_cnt_d = '0;
                            state_d   = rxs ? S_IDLE : S_DATA;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_tick) begin
                        if (cnt_q == FULL_M1) begin
                            cnt_d   = '0;
                            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_d  = '0;
                                par_flag_d = 1'b0;
                                state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (sample_tick) begin
                        if (cnt_q == FULL_M1) begin
                            cnt_d      = '0;
                            par_flag_d = (^shift_q) ^ rxs ^ (PARITY_ODD != 0);
                            state_d    = S_STOP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (sample_tick) begin
                        if (cnt_q == FULL_M1) begin
                            cnt_d      = '0;
                            stop_bit_d = rxs;
                            commit_d   = 1'b1;
                            state_d    = rxs ? S_IDLE : S_WAIT_HIGH;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Holding register: commit one clk after the stop sample, ack handshake, overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        if (commit_q) begin
            rx_data_d    = shift_q;
            frame_err_d  = !stop_bit_q;
            parity_err_d = par_flag_q;
            rx_valid_d   = 1'b1;
            if (rx_valid_q && !rd_ack) overrun_d = 1'b1;
        end else if (rd_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    // Outputs: busy decoded from state, the rest straight from the holding register.
    always_comb begin
        busy        = (state_q != S_IDLE);
        rx_data     = rx_data_q;
        rx_valid    = rx_valid_q;
        frame_err   = frame_err_q;
        parity_err  = parity_err_q;
        overrun_err = overrun_q;
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames into an 8N1 instance and an 8E1 instance,
// expected bytes queued at send time and compared when the receiver commits.
module tb_uart_rx_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable_rx, sample_tick, rx_a, rx_b, rd_ack;
    logic [7:0] rx_data_a, rx_data_b;
    logic rx_valid_a, ferr_a, perr_a, ovr_a, busy_a;
    logic rx_valid_b, ferr_b, perr_b, ovr_b, busy_b;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .enable_rx(enable_rx), .sample_tick(sample_tick),
        .rx_serial(rx_a), .rd_ack(rd_ack), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun_err(ovr_a), .busy(busy_a)
    );

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst(rst), .enable_rx(enable_rx), .sample_tick(sample_tick),
        .rx_serial(rx_b), .rd_ack(rd_ack), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
        .frame_err(ferr_b), .parity_err(perr_b), .overrun_err(ovr_b), .busy(busy_b)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    logic rv_prev = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid_a && !rv_prev) rise_cyc <= cyc;
        rv_prev <= rx_valid_a;
    end

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic f, input logic p);
        exp_t e;
        e.data = d;
        e.ferr = f;
        e.perr = p;
        sb.push_back(e);
    endtask

    task automatic set_line(input bit p, input logic v);
        if (p) rx_b = v;
        else   rx_a = v;
    endtask

    task automatic send_bit(input bit p, input logic v, input bit gap);
        set_line(p, v);
        if (gap) begin
            clks(8);
            sample_tick = 1'b0;
            clks(40);
            chk("gap_busy", {31'd0, busy_a}, 32'd1);
            sample_tick = 1'b1;
            clks(8);
        end else begin
            clks(16);
        end
    endtask

    task automatic send_frame(input bit p, input logic [7:0] d, input logic par,
                              input logic stop, input int gap_bit);
        start_cyc = cyc;
        send_bit(p, 1'b0, gap_bit == 0);
        for (int i = 0; i < 8; i++) send_bit(p, d[i], gap_bit == i + 1);
        if (p) send_bit(p, par, 1'b0);
        send_bit(p, stop, 1'b0);
    endtask

    task automatic pop_check(input bit p, input string tag);
        exp_t e;
        logic v;
        v = p ? rx_valid_b : rx_valid_a;
        for (int i = 0; i < 32 && !v; i++) begin
            clks(1);
            v = p ? rx_valid_b : rx_valid_a;
        end
        chk({tag, "_valid"}, {31'd0, v}, 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, {24'd0, (p ? rx_data_b : rx_data_a)}, {24'd0, e.data});
            chk({tag, "_ferr"}, {31'd0, (p ? ferr_b : ferr_a)}, {31'd0, e.ferr});
            chk({tag, "_perr"}, {31'd0, (p ? perr_b : perr_a)}, {31'd0, e.perr});
        end
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        clks(1);
        rd_ack = 1'b0;
        clks(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; enable_rx = 1'b1; sample_tick = 1'b1;
        rx_a = 1'b1; rx_b = 1'b1; rd_ack = 1'b0;
        clks(3);
        chk("rst_data_a",  {24'd0, rx_data_a}, 32'd0);
        chk("rst_valid_a", {31'd0, rx_valid_a}, 32'd0);
        chk("rst_ferr_a",  {31'd0, ferr_a}, 32'd0);
        chk("rst_perr_a",  {31'd0, perr_a}, 32'd0);
        chk("rst_ovr_a",   {31'd0, ovr_a}, 32'd0);
        chk("rst_busy_a",  {31'd0, busy_a}, 32'd0);
        chk("rst_flags_b", {24'd0, rx_data_b, rx_valid_b, ferr_b, perr_b, ovr_b, busy_b}, 32'd0);
        rst = 1'b1;
        clks(5);

        // Plain 8N1 frame.
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1);
        pop_check(1'b0, "a5");
        chk("a5_busy", {31'd0, busy_a}, 32'd0);
        chk("a5_latency", {31'd0, (rise_cyc - start_cyc >= 150) && (rise_cyc - start_cyc <= 170)}, 32'd1);
        ack();
        chk("a5_ack", {31'd0, rx_valid_a}, 32'd0);

        // Short low glitch: false start.
        rx_a = 1'b0;
        clks(4);
        rx_a = 1'b1;
        clks(2);
        chk("glitch_start", {31'd0, busy_a}, 32'd1);
        clks(20);
        chk("glitch_idle", {31'd0, busy_a}, 32'd0);
        chk("glitch_valid", {31'd0, rx_valid_a}, 32'd0);

        // Stop bit 0, line held low, then recovery.
        push_exp(8'h3C, 1'b1, 1'b0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, -1);
        clks(40);
        pop_check(1'b0, "3c");
        chk("wait_high", {31'd0, busy_a}, 32'd1);
        rx_a = 1'b1;
        clks(5);
        chk("wait_release", {31'd0, busy_a}, 32'd0);
        ack();
        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(1'b0, 8'h11, 1'b0, 1'b1, -1);
        pop_check(1'b0, "11");
        ack();

        // Tick stream paused mid-frame: receiver must hold.
        push_exp(8'hC3, 1'b0, 1'b0);
        send_frame(1'b0, 8'hC3, 1'b0, 1'b1, 3);
        pop_check(1'b0, "gap");
        ack();

        // Overrun.
        push_exp(8'h01, 1'b0, 1'b0);
        send_frame(1'b0, 8'h01, 1'b0, 1'b1, -1);
        pop_check(1'b0, "ov1");
        chk("ov1_flag", {31'd0, ovr_a}, 32'd0);
        push_exp(8'h02, 1'b0, 1'b0);
        send_frame(1'b0, 8'h02, 1'b0, 1'b1, -1);
        pop_check(1'b0, "ov2");
        chk("ov2_flag", {31'd0, ovr_a}, 32'd1);
        ack();
        chk("ov_ack_valid", {31'd0, rx_valid_a}, 32'd0);
        chk("ov_ack_flag", {31'd0, ovr_a}, 32'd0);

        // Even parity on the second instance.
        push_exp(8'h07, 1'b0, 1'b1);
        send_frame(1'b1, 8'h07, 1'b0, 1'b1, -1);
        pop_check(1'b1, "par_bad");
        ack();
        push_exp(8'h07, 1'b0, 1'b0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, -1);
        pop_check(1'b1, "par_good");
        ack();

        // Enable dropped after data bit 3; no start while disabled.
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
        enable_rx = 1'b0;
        rx_a = 1'b1;
        clks(10);
        rx_a = 1'b0;
        clks(30);
        chk("dis_nostart", {31'd0, busy_a}, 32'd0);
        rx_a = 1'b1;
        clks(5);
        enable_rx = 1'b1;
        clks(20);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_valid", {31'd0, rx_valid_a}, 32'd0);
        chk("abort_keep", {24'd0, rx_data_a}, 32'h02);
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1, -1);
        pop_check(1'b0, "5a");

        // Reset mid-frame with an unread byte held.
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        clks(1);
        rst = 1'b1;
        rx_a = 1'b1;
        chk("mrst_data", {24'd0, rx_data_a}, 32'd0);
        chk("mrst_valid", {31'd0, rx_valid_a}, 32'd0);
        chk("mrst_busy", {31'd0, busy_a}, 32'd0);
        chk("mrst_flags", {29'd0, ferr_a, perr_a, ovr_a}, 32'd0);
        clks(200);
        chk("mrst_nocommit", {31'd0, rx_valid_a}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
